// File: rtl/ball_motion_engine.sv
// Rectangular bouncing-ball engine: serve/pause/restart control, collision rings learned
// from the raster 'empty' stream, wall confinement, bounce pulses and a saturating hit counter.
module ball_motion_engine #(
  parameter int XLOC_START = 320,
  parameter int YLOC_START = 240,
  parameter int XDIR_START = 0,
  parameter int YDIR_START = 0,
  parameter int BALL_W     = 21,
  parameter int BALL_H     = 21,
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  parameter int SPEED_W    = 3,
  parameter int HIT_W      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pixpulse,
  input  logic [9:0]         hcount,
  input  logic [9:0]         vcount,
  input  logic               empty,
  input  logic               move,
  input  logic               serve,
  input  logic               pause,
  input  logic               restart,
  input  logic [SPEED_W-1:0] speed,
  output logic               draw_ball,
  output logic [9:0]         xloc,
  output logic [9:0]         yloc,
  output logic               xdir,
  output logic               ydir,
  output logic               bounce_x,
  output logic               bounce_y,
  output logic [HIT_W-1:0]   hit_count,
  output logic [1:0]         state
);
  localparam int HW = (BALL_W - 1) / 2;
  localparam int HH = (BALL_H - 1) / 2;

  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10} state_t;

  state_t             st;
  logic [SPEED_W-1:0] move_cnt;
  logic [BALL_H+1:0]  lft, rgt, lft_set, rgt_set;
  logic [BALL_W+1:0]  top, bot, top_set, bot_set;
  logic               ring_clr_pend;
  logic               ring_clr;

  logic [10:0] hc, vc, xw, yw, hidx, vidx, x_next, y_next;
  logic        x_ring, y_ring, corner, corner_only, x_wall, y_wall, flip_x, flip_y;
  logic [HIT_W:0] hit_sum;
  logic [HIT_W-1:0] hit_next;

  assign hc    = {1'b0, hcount};
  assign vc    = {1'b0, vcount};
  assign xw    = {1'b0, xloc};
  assign yw    = {1'b0, yloc};
  assign state = st;

  // Out-of-window pixels wrap to huge indices and match no ring bit.
  assign vidx = yw + 11'(HH + 1) - vc;
  assign hidx = xw + 11'(HW + 1) - hc;

  always_comb begin
    lft_set = '0;
    rgt_set = '0;
    top_set = '0;
    bot_set = '0;
    for (int i = 0; i < BALL_H + 2; i++) begin
      if (!empty && vidx == 11'(i)) begin
        if (hc == xw - 11'(HW + 1)) lft_set[i] = 1'b1;
        if (hc == xw + 11'(HW + 1)) rgt_set[i] = 1'b1;
      end
    end
    for (int i = 0; i < BALL_W + 2; i++) begin
      if (!empty && hidx == 11'(i)) begin
        if (vc == yw - 11'(HH + 1)) top_set[i] = 1'b1;
        if (vc == yw + 11'(HH + 1)) bot_set[i] = 1'b1;
      end
    end
  end

  always_comb begin
    if (xdir) x_ring = ydir ? |rgt[BALL_H-1:1] : |rgt[BALL_H:2];
    else      x_ring = ydir ? |lft[BALL_H-1:1] : |lft[BALL_H:2];
    if (ydir) y_ring = xdir ? |bot[BALL_W-1:1] : |bot[BALL_W:2];
    else      y_ring = xdir ? |top[BALL_W-1:1] : |top[BALL_W:2];
    case ({xdir, ydir})
      2'b00:   corner = lft[BALL_H+1] | top[BALL_W+1];
      2'b01:   corner = lft[0] | bot[BALL_W+1];
      2'b10:   corner = rgt[BALL_H+1] | top[0];
      default: corner = rgt[0] | bot[0];
    endcase
  end

  assign corner_only = corner & ~x_ring & ~y_ring;
  assign x_wall = xdir ? (xw + 11'(HW + 1) > 11'(SCREEN_W - 2)) : (xw < 11'(HW + 2));
  assign y_wall = ydir ? (yw + 11'(HH + 1) > 11'(SCREEN_H - 2)) : (yw < 11'(HH + 2));
  assign flip_x = x_ring | corner_only | x_wall;
  assign flip_y = y_ring | corner_only | y_wall;
  assign x_next = (xdir ^ flip_x) ? xw + 11'd1 : xw - 11'd1;
  assign y_next = (ydir ^ flip_y) ? yw + 11'd1 : yw - 11'd1;

  assign hit_sum  = {1'b0, hit_count} + {{HIT_W{1'b0}}, flip_x} + {{HIT_W{1'b0}}, flip_y};
  assign hit_next = hit_sum[HIT_W] ? '1 : hit_sum[HIT_W-1:0];

  assign ring_clr = ring_clr_pend | (st == IDLE && serve && !restart);

  assign draw_ball = (hc + 11'(HW) >= xw) && (hc <= xw + 11'(HW)) &&
                     (vc + 11'(HH) >= yw) && (vc <= yw + 11'(HH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st            <= IDLE;
      xloc          <= 10'(XLOC_START);
      yloc          <= 10'(YLOC_START);
      xdir          <= 1'(XDIR_START);
      ydir          <= 1'(YDIR_START);
      move_cnt      <= '0;
      lft           <= '0;
      rgt           <= '0;
      top           <= '0;
      bot           <= '0;
      ring_clr_pend <= 1'b0;
      bounce_x      <= 1'b0;
      bounce_y      <= 1'b0;
      hit_count     <= '0;
    end else begin
      bounce_x <= 1'b0;
      bounce_y <= 1'b0;
      if (pixpulse) begin
        ring_clr_pend <= 1'b0;
        if (ring_clr) begin
          lft <= '0;
          rgt <= '0;
          top <= '0;
          bot <= '0;
        end else begin
          lft <= lft | lft_set;
          rgt <= rgt | rgt_set;
          top <= top | top_set;
          bot <= bot | bot_set;
        end
        if (restart) begin
          st       <= IDLE;
          xloc     <= 10'(XLOC_START);
          yloc     <= 10'(YLOC_START);
          xdir     <= 1'(XDIR_START);
          ydir     <= 1'(YDIR_START);
          move_cnt <= '0;
        end else begin
          case (st)
            IDLE: if (serve) begin
              st       <= RUN;
              xdir     <= 1'(XDIR_START);
              ydir     <= 1'(YDIR_START);
              move_cnt <= '0;
            end
            RUN: if (pause) begin
              st <= PAUSE;
            end else if (move) begin
              // >= so that lowering speed below the running count steps on the next strobe
              if (move_cnt >= speed) begin
                move_cnt      <= '0;
                xloc          <= x_next[9:0];
                yloc          <= y_next[9:0];
                xdir          <= xdir ^ flip_x;
                ydir          <= ydir ^ flip_y;
                bounce_x      <= flip_x;
                bounce_y      <= flip_y;
                hit_count     <= hit_next;
                ring_clr_pend <= 1'b1;
              end else begin
                move_cnt <= move_cnt + SPEED_W'(1);
              end
            end
            PAUSE: if (!pause) st <= RUN;
            default: st <= IDLE;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_ball_motion_engine.sv
// Bench for ball_motion_engine: draw_ball vector table plus scoreboarded multi-step sequences
// checked against a geometric model of obstacles, walls and the serve/pause/restart FSM.
module tb_ball_motion_engine;
  localparam int HW = 10;
  localparam int HH = 10;

  logic       clk = 1'b0, rst_n = 1'b0, pixpulse = 1'b0, empty = 1'b1;
  logic       move = 1'b0, serve = 1'b0, pause = 1'b0, restart = 1'b0;
  logic [9:0] hcount = '0, vcount = '0;
  logic [2:0] speed = '0;
  logic       draw_ball, xdir, ydir, bounce_x, bounce_y;
  logic [9:0] xloc, yloc;
  logic [7:0] hit_count;
  logic [1:0] state;

  ball_motion_engine dut (
    .clk(clk), .rst_n(rst_n), .pixpulse(pixpulse), .hcount(hcount), .vcount(vcount),
    .empty(empty), .move(move), .serve(serve), .pause(pause), .restart(restart),
    .speed(speed), .draw_ball(draw_ball), .xloc(xloc), .yloc(yloc), .xdir(xdir),
    .ydir(ydir), .bounce_x(bounce_x), .bounce_y(bounce_y), .hit_count(hit_count),
    .state(state)
  );

  always #5 clk = ~clk;

  int nbx = 0, nby = 0;
  always @(posedge clk) begin
    if (bounce_x) nbx++;
    if (bounce_y) nby++;
  end

  typedef struct {string name; int sel; int exp;} sb_t;
  typedef struct {int x; int y;} pt_t;
  typedef struct {int h; int v; int e;} vec_t;

  sb_t sbq[$];
  pt_t obs[$];
  int  tests = 0, fails = 0;
  int  mx = 320, my = 240, mdx = 0, mdy = 0, mst = 0, mcnt = 0, mhit = 0, mbx = 0, mby = 0;
  bit  track = 1'b0;

  function automatic int get_sig(int sel);
    case (sel)
      0: return int'(xloc);
      1: return int'(yloc);
      2: return int'(xdir);
      3: return int'(ydir);
      4: return int'(state);
      5: return int'(hit_count);
      6: return int'(draw_ball);
      7: return nbx;
      8: return nby;
      9: return int'(bounce_x);
      default: return int'(bounce_y);
    endcase
  endfunction

  task automatic push(string n, int sel, int e);
    sbq.push_back('{n, sel, e});
  endtask

  task automatic drain();
    while (sbq.size() > 0) begin
      sb_t s;
      s = sbq.pop_front();
      tests++;
      if (get_sig(s.sel) !== s.exp) begin
        fails++;
        $display("FAIL %s: got %0d expected %0d", s.name, get_sig(s.sel), s.exp);
      end
    end
  endtask

  task automatic push_model(string t);
    push({t, " xloc"}, 0, mx);
    push({t, " yloc"}, 1, my);
    push({t, " xdir"}, 2, mdx);
    push({t, " ydir"}, 3, mdy);
    push({t, " state"}, 4, mst);
    push({t, " hit"}, 5, mhit);
    push({t, " bx pulses"}, 7, mbx);
    push({t, " by pulses"}, 8, mby);
  endtask

  // Geometric reference: obstacles in the heading-side window, corners, and screen walls.
  task automatic m_step();
    bit xb = 0, yb = 0, cr = 0, fx, fy, wx, wy;
    int ex = (mdx != 0) ? mx + HW + 1 : mx - HW - 1;
    int ey = (mdy != 0) ? my + HH + 1 : my - HH - 1;
    int ylo = (mdy != 0) ? my - HH + 1 : my - HH;
    int yhi = (mdy != 0) ? my + HH : my + HH - 1;
    int xlo = (mdx != 0) ? mx - HW + 1 : mx - HW;
    int xhi = (mdx != 0) ? mx + HW : mx + HW - 1;
    foreach (obs[i]) begin
      if (obs[i].x == ex && obs[i].y >= ylo && obs[i].y <= yhi) xb = 1;
      if (obs[i].y == ey && obs[i].x >= xlo && obs[i].x <= xhi) yb = 1;
      if (obs[i].x == ex && obs[i].y == ey) cr = 1;
    end
    wx = (mdx != 0) ? (mx + 1 + HW > 638) : (mx - 1 - HW < 1);
    wy = (mdy != 0) ? (my + 1 + HH > 478) : (my - 1 - HH < 1);
    fx = xb | wx | (cr & !xb & !yb);
    fy = yb | wy | (cr & !xb & !yb);
    mx = mx + ((((mdx != 0) ? 1'b1 : 1'b0) ^ fx) ? 1 : -1);
    my = my + ((((mdy != 0) ? 1'b1 : 1'b0) ^ fy) ? 1 : -1);
    if (fx) mdx = 1 - mdx;
    if (fy) mdy = 1 - mdy;
    mhit = mhit + int'(fx) + int'(fy);
    if (mhit > 255) mhit = 255;
    mbx += int'(fx);
    mby += int'(fy);
  endtask

  task automatic m_pix(bit mv, bit sv, bit ps, bit rs);
    if (rs) begin
      mst = 0; mx = 320; my = 240; mdx = 0; mdy = 0; mcnt = 0;
    end else begin
      case (mst)
        0: if (sv) begin mst = 1; mdx = 0; mdy = 0; mcnt = 0; end
        1: if (ps) mst = 2;
           else if (mv) begin
             if (mcnt >= int'(speed)) begin m_step(); mcnt = 0; end
             else mcnt++;
           end
        2: if (!ps) mst = 1;
        default: ;
      endcase
    end
  endtask

  task automatic pix(int h, int v, bit e, bit mv, bit sv, bit ps, bit rs);
    hcount = 10'(h); vcount = 10'(v); empty = e; move = mv;
    serve = sv; pause = ps; restart = rs; pixpulse = 1'b1;
    m_pix(mv, sv, ps, rs);
    @(posedge clk); #1;
    pixpulse = 1'b0; move = 1'b0; serve = 1'b0; restart = 1'b0; empty = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  function automatic bit on_ring(pt_t p);
    return ((p.x == mx - HW - 1 || p.x == mx + HW + 1) && p.y >= my - HH - 1 && p.y <= my + HH + 1) ||
           ((p.y == my - HH - 1 || p.y == my + HH + 1) && p.x >= mx - HW - 1 && p.x <= mx + HW + 1);
  endfunction

  // One move cycle: spare pixpulse (ring clear after a step), paint ring obstacles, strobe.
  task automatic advance();
    pix(0, 0, 1, 0, 0, 0, 0);
    if (track) begin
      obs.delete();
      obs.push_back('{mx - HW - 1, my});
      obs.push_back('{mx + HW + 1, my});
      obs.push_back('{mx, my - HH - 1});
      obs.push_back('{mx, my + HH + 1});
    end
    foreach (obs[i]) if (on_ring(obs[i])) pix(obs[i].x, obs[i].y, 0, 0, 0, 0, 0);
    pix(0, 0, 1, 1, 0, 0, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: run exceeded time limit after %0d checks", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[8];
    vt = '{'{310, 240, 1}, '{309, 240, 0}, '{330, 250, 1}, '{331, 240, 0},
           '{320, 229, 0}, '{320, 230, 1}, '{320, 251, 0}, '{0, 0, 0}};

    #3;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    push_model("reset");
    push("reset bounce_x", 9, 0);
    push("reset bounce_y", 10, 0);
    drain();

    foreach (vt[i]) begin
      hcount = 10'(vt[i].h);
      vcount = 10'(vt[i].v);
      #1;
      push($sformatf("draw vec %0d", i), 6, vt[i].e);
      drain();
    end

    // serve with a simultaneous move strobe: transition only
    pix(0, 0, 1, 1, 1, 0, 0);
    push("serve no step", 0, 320);
    push("serve state", 4, 1);
    drain();
    repeat (10) advance();
    push("t1 xloc", 0, 310);
    push("t1 yloc", 1, 230);
    push("t1 hit", 5, 0);
    push("t1 state", 4, 1);
    push_model("t1");
    drain();

    speed = 3'd3;
    repeat (8) advance();
    push("t2 xloc 2 steps", 0, 308);
    push("t2 yloc 2 steps", 1, 228);
    drain();
    repeat (2) advance();
    pix(0, 0, 1, 0, 0, 1, 0);
    push("t2 paused", 4, 2);
    drain();
    repeat (5) pix(0, 0, 1, 1, 0, 1, 0);
    push("t2 pause xloc", 0, 308);
    push("t2 pause yloc", 1, 228);
    push("t2 pause state", 4, 2);
    drain();
    pix(0, 0, 1, 0, 0, 0, 0);
    push("t2 resume", 4, 1);
    advance();
    push("t2 cnt held no step", 0, 308);
    drain();
    advance();
    push("t2 step after hold", 0, 307);
    drain();
    repeat (2) advance();
    speed = 3'd1;
    advance();
    push("t2 lowered speed step", 0, 306);
    push_model("t2");
    drain();
    speed = 3'd0;

    pix(0, 0, 1, 0, 0, 0, 1);
    pix(0, 0, 1, 0, 1, 0, 0);
    repeat (8) advance();
    for (int y = 0; y < 480; y++) obs.push_back('{300, y});
    advance();
    push("t3 pre xloc", 0, 311);
    push("t3 pre xdir", 2, 0);
    drain();
    advance();
    push("t3 xloc", 0, 312);
    push("t3 xdir", 2, 1);
    push("t3 hit", 5, 1);
    push("t3 bx pulses", 7, 1);
    push_model("t3");
    drain();

    obs.delete();
    pix(0, 0, 1, 0, 0, 0, 1);
    pix(0, 0, 1, 0, 1, 0, 0);
    obs.push_back('{320 - HW - 1, 240 - HH - 1});
    advance();
    push("t4 xloc", 0, 321);
    push("t4 yloc", 1, 241);
    push("t4 xdir", 2, 1);
    push("t4 ydir", 3, 1);
    push("t4 hit", 5, 3);
    push_model("t4");
    drain();

    obs.delete();
    pix(0, 0, 1, 0, 0, 0, 1);
    pix(0, 0, 1, 0, 1, 0, 0);
    for (int i = 0; i < 400 && !(mx == HW + 1 && mdx == 0); i++) advance();
    push("t5 reached wall", 0, HW + 1);
    push("t5 heading left", 2, 0);
    drain();
    advance();
    push("t5 xdir flipped", 2, 1);
    push("t5 xloc", 0, HW + 2);
    push_model("t5");
    drain();

    pix(0, 0, 1, 0, 0, 0, 1);
    pix(0, 0, 1, 0, 1, 0, 0);
    repeat (3) advance();
    pix(320 - HW - 1, 240, 0, 0, 0, 0, 0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    mst = 0; mx = 320; my = 240; mdx = 0; mdy = 0; mcnt = 0; mhit = 0;
    push("t6 rst xloc", 0, 320);
    push("t6 rst yloc", 1, 240);
    push("t6 rst state", 4, 0);
    push("t6 rst hit", 5, 0);
    push("t6 rst xdir", 2, 0);
    push("t6 rst bounce_x", 9, 0);
    push("t6 rst bounce_y", 10, 0);
    drain();
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    pix(0, 0, 1, 0, 1, 0, 0);
    push("t6 serve", 4, 1);
    drain();
    pix(0, 0, 1, 0, 1, 0, 1);
    push("t6 restart beats serve", 4, 0);
    drain();
    pix(0, 0, 1, 0, 1, 0, 0);
    advance();
    pix(0, 0, 1, 0, 0, 1, 1);
    push("t6 restart beats pause", 4, 0);
    push("t6 restart xloc", 0, 320);
    drain();

    pix(0, 0, 1, 0, 1, 0, 0);
    track = 1'b1;
    repeat (127) advance();
    push("sat hit 254", 5, 254);
    drain();
    advance();
    push("sat hit 255", 5, 255);
    drain();
    repeat (3) advance();
    push("sat hit held", 5, 255);
    push_model("sat");
    drain();
    track = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
